// File: rtl/lut_loader_pkg.sv
// rtl/lut_loader_pkg.sv - shared types and defaults for the LUT loader
package lut_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_H = 3'd1,
        ST_LOAD_V = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // Default table sizes and inter-byte timeout (clk cycles)
    localparam int H_LEN_DEF   = 720;
    localparam int V_LEN_DEF   = 1280;
    localparam int TIMEOUT_DEF = 65535;

    // Read/write address widths of the two tables
    localparam int H_AW = 10;
    localparam int V_AW = 11;

endpackage

// File: rtl/lut_loader_ram.sv
// rtl/lut_loader_ram.sv - byte-wide LUT storage with one write port and one synchronous read port
module lut_ram #(
    parameter int DEPTH = 720,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Table write; contents survive reset so a reload overwrites in place
    always_ff @(posedge clk) begin
        if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; same-cycle write to the same entry returns the old byte
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q <= 8'h00;
        end else if (int'(rd_addr_i) < DEPTH) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lut_loader.sv
// rtl/lut_loader.sv - loads H and V lookup tables from a byte stream read off the SD card
module lut_loader
    import lut_loader_pkg::*;
#(
    parameter int H_LEN   = H_LEN_DEF,
    parameter int V_LEN   = V_LEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_byte,
    input  logic [H_AW-1:0] rd_h_addr,
    output logic [7:0]      rd_h_data,
    input  logic [V_AW-1:0] rd_v_addr,
    output logic [7:0]      rd_v_data,
    output logic            lut_rdy,
    output logic            busy,
    output logic            err,
    output logic            extra
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [V_AW-1:0] H_LAST    = V_AW'(H_LEN - 1);
    localparam logic [V_AW-1:0] V_LAST    = V_AW'(V_LEN - 1);

    state_e          state_q, state_d;
    logic            start_q;
    logic            start_edge;
    logic [V_AW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            extra_q, extra_d;
    logic            lut_rdy_q, busy_q, err_q;
    logic            h_we, v_we;

    assign start_edge = start & ~start_q;

    // Registered copy of start for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // State, counters and status flags; flags follow the state being entered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            extra_q   <= 1'b0;
            lut_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            extra_q   <= extra_d;
            lut_rdy_q <= (state_d == ST_DONE);
            busy_q    <= (state_d == ST_LOAD_H) || (state_d == ST_LOAD_V);
            err_q     <= (state_d == ST_ERR);
        end
    end

    // Next-state logic: route each byte to the right table and watch for stalls
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        extra_d = extra_q;
        h_we    = 1'b0;
        v_we    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // A byte arriving with the start edge belongs to no load and is dropped
                if (start_edge) begin
                    state_d = ST_LOAD_H;
                    cnt_d   = '0;
                    idle_d  = '0;
                    extra_d = 1'b0;
                end else if ((state_q == ST_DONE) && in_valid) begin
                    extra_d = 1'b1;
                end
            end
            ST_LOAD_H, ST_LOAD_V: begin
                if (in_valid) begin
                    // A byte always wins over a timeout landing on the same cycle
                    idle_d = '0;
                    if (state_q == ST_LOAD_H) begin
                        h_we = 1'b1;
                        if (cnt_q == H_LAST) begin
                            state_d = ST_LOAD_V;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        v_we = 1'b1;
                        if (cnt_q == V_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    lut_ram #(
        .DEPTH (H_LEN),
        .AW    (H_AW)
    ) u_h_lut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (h_we),
        .wr_addr_i (cnt_q[H_AW-1:0]),
        .wr_data_i (in_byte),
        .rd_addr_i (rd_h_addr),
        .rd_data_o (rd_h_data)
    );

    lut_ram #(
        .DEPTH (V_LEN),
        .AW    (V_AW)
    ) u_v_lut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (v_we),
        .wr_addr_i (cnt_q),
        .wr_data_i (in_byte),
        .rd_addr_i (rd_v_addr),
        .rd_data_o (rd_v_data)
    );

    assign lut_rdy = lut_rdy_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign extra   = extra_q;

endmodule

// File: tb/tb_lut_loader.sv
// tb/tb_lut_loader.sv - self-checking bench for lut_loader
module tb_lut_loader;

    localparam int H  = 720;
    localparam int V  = 1280;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn, start, in_valid;
    logic [7:0]  in_byte;
    logic [9:0]  rd_h_addr;
    logic [10:0] rd_v_addr;
    logic [7:0]  rd_h_data, rd_v_data;
    logic        lut_rdy, busy, err, extra;

    int errors = 0;
    int checks = 0;

    always #50 clk = ~clk;

    lut_loader #(
        .H_LEN   (H),
        .V_LEN   (V),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .rd_h_addr (rd_h_addr),
        .rd_h_data (rd_h_data),
        .rd_v_addr (rd_v_addr),
        .rd_v_data (rd_v_data),
        .lut_rdy   (lut_rdy),
        .busy      (busy),
        .err       (err),
        .extra     (extra)
    );

    // Reference model: file byte k of a load goes to H[k] or V[k-H]
    logic [7:0] h_m [H];
    logic [7:0] v_m [V];
    bit m_active, m_done, m_err, m_extra, m_sprev;
    int m_cnt, m_idle;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_extra = 0; m_sprev = 0;
        m_cnt = 0; m_idle = 0;
    endfunction

    function automatic void model_feed(input logic [7:0] b);
        if (m_active) begin
            m_idle = 0;
            if (m_cnt < H) h_m[m_cnt] = b;
            else v_m[m_cnt - H] = b;
            m_cnt++;
            if (m_cnt == H + V) begin
                m_active = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_extra = 1;
        end
    endfunction

    function automatic void model_idle();
        if (m_active) begin
            m_idle++;
            if (m_idle >= TO) begin
                m_active = 0;
                m_err = 1;
            end
        end
    endfunction

    function automatic logic [7:0] exp_h(input int a);
        return (a < H) ? h_m[a] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_v(input int a);
        return (a < V) ? v_m[a] : 8'h00;
    endfunction

    // Advance one clock, updating the model from the inputs applied this cycle
    task automatic step();
        if (!rstn) begin
            model_reset();
        end else begin
            if (start && !m_sprev && !m_active) begin
                m_active = 1; m_done = 0; m_err = 0; m_extra = 0;
                m_cnt = 0; m_idle = 0;
            end else if (in_valid) begin
                model_feed(in_byte);
            end else begin
                model_idle();
            end
            m_sprev = start;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic reload();
        in_valid = 1'b0;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
    endtask

    task automatic rd_check(input bit is_v, input int a, input logic [7:0] exp, input string nm);
        in_valid = 1'b0;
        if (is_v) rd_v_addr = 11'(a);
        else rd_h_addr = 10'(a);
        step();
        chk(nm, is_v ? rd_v_data : rd_h_data, exp);
    endtask

    task automatic status(input string nm);
        chk({nm, "_busy"}, busy, m_active);
        chk({nm, "_rdy"}, lut_rdy, m_done);
        chk({nm, "_err"}, err, m_err);
        chk({nm, "_extra"}, extra, m_extra);
    endtask

    task automatic random_reads(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            bit is_v;
            int a;
            is_v = 1'($urandom);
            a = is_v ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 1023));
            rd_check(is_v, a, is_v ? exp_v(a) : exp_h(a), nm);
        end
    endtask

    typedef struct {
        bit         is_v;
        int         addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[10];
    logic [7:0] old;
    int bad;

    initial begin
        // Expected contents after a load of 2000 bytes with value = index[7:0]
        vecs[0] = '{0, 719,  8'hCF};
        vecs[1] = '{1, 0,    8'hD0};
        vecs[2] = '{0, 0,    8'h00};
        vecs[3] = '{0, 255,  8'hFF};
        vecs[4] = '{1, 100,  8'h34};
        vecs[5] = '{1, 1279, 8'hCF};
        vecs[6] = '{0, 720,  8'h00};
        vecs[7] = '{0, 1023, 8'h00};
        vecs[8] = '{1, 1280, 8'h00};
        vecs[9] = '{1, 2047, 8'h00};

        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        rd_h_addr = '0; rd_v_addr = '0;
        model_reset();
        step();
        step();
        chk("rst_rdy", lut_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_extra", extra, 1'b0);
        chk("rst_rdh", rd_h_data, 8'h00);
        chk("rst_rdv", rd_v_data, 8'h00);
        rstn = 1'b1;
        step();

        // Contiguous load of index-valued bytes
        start = 1'b1;
        step();
        chk("t1_busy", busy, 1'b1);
        for (int k = 0; k < H + V; k++) begin
            feed(8'(k));
            if (k == H + V - 2) chk("t1_rdy_early", lut_rdy, 1'b0);
        end
        chk("t1_rdy", lut_rdy, 1'b1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_extra", extra, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rd_check(vecs[i].is_v, vecs[i].addr, vecs[i].exp, $sformatf("t1_vec%0d", i));
        end

        // Reload with random bytes and random gaps; read-during-write returns old data
        reload();
        status("t2_start");
        bad = 0;
        for (int k = 0; k < H + V; k++) begin
            in_valid = 1'b1;
            in_byte = 8'($urandom);
            if (k == 0) begin
                rd_h_addr = 10'd0;
                old = h_m[0];
            end
            step();
            if (k == 0) chk("t2_rdw", rd_h_data, old);
            in_valid = 1'b0;
            if (k < H + V - 1) begin
                if (!busy || lut_rdy) bad++;
                repeat ($urandom_range(0, 5)) begin
                    step();
                    if (!busy || lut_rdy) bad++;
                end
            end
        end
        chk("t2_gap_cycles_bad", bad, 0);
        chk("t2_rdy", lut_rdy, 1'b1);
        status("t2_end");
        random_reads(40, "t2_rand_rd");

        // Overrun: 2003 bytes sets extra and leaves V[1279] intact
        reload();
        for (int k = 0; k < H + V + 3; k++) begin
            feed(8'(k));
            if (k == H + V - 1) chk("t3_extra_early", extra, 1'b0);
        end
        chk("t3_rdy", lut_rdy, 1'b1);
        chk("t3_extra", extra, 1'b1);
        status("t3_end");
        rd_check(1, 1279, 8'hCF, "t3_v1279");

        // Byte coincident with start edge is discarded
        start = 1'b0;
        step();
        start = 1'b1; in_valid = 1'b1; in_byte = 8'hAA;
        step();
        chk("t4_extra_clr", extra, 1'b0);
        chk("t4_busy", busy, 1'b1);
        feed(8'h55);
        rd_check(0, 0, 8'h55, "t4_h0");

        // Timeout: a byte on the would-be timeout cycle wins, then 16 silent cycles abort
        for (int k = 1; k < 100; k++) begin
            feed(8'($urandom));
            if (k == 49) repeat (TO - 1) step();
            if (k == 50) begin
                chk("t5_coinc_err", err, 1'b0);
                chk("t5_coinc_busy", busy, 1'b1);
            end
        end
        repeat (TO - 1) step();
        chk("t5_err_early", err, 1'b0);
        chk("t5_busy_early", busy, 1'b1);
        step();
        chk("t5_err", err, 1'b1);
        chk("t5_rdy", lut_rdy, 1'b0);
        chk("t5_busy", busy, 1'b0);
        feed(8'h11);
        status("t5_err_byte");
        reload();
        chk("t5_reload_err", err, 1'b0);
        for (int k = 0; k < H + V; k++) feed(8'($urandom));
        chk("t5_reload_rdy", lut_rdy, 1'b1);
        status("t5_reload");
        random_reads(10, "t5_rand_rd");

        // Reset mid-load aborts; later bytes ignored until a start edge
        reload();
        for (int k = 0; k < 500; k++) feed(8'($urandom));
        chk("t6_busy", busy, 1'b1);
        rstn = 1'b0;
        start = 1'b0;
        step();
        chk("t6_rdy", lut_rdy, 1'b0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_err", err, 1'b0);
        chk("t6_extra", extra, 1'b0);
        chk("t6_rdh", rd_h_data, 8'h00);
        chk("t6_rdv", rd_v_data, 8'h00);
        rstn = 1'b1;
        step();
        for (int k = 0; k < 10; k++) feed(8'($urandom));
        chk("t6_ignored_busy", busy, 1'b0);
        status("t6_after");
        for (int i = 0; i < 5; i++) rd_check(0, i, exp_h(i), "t6_h_kept");
        start = 1'b1;
        step();
        chk("t6_restart_busy", busy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_loader.md
LUT_LOADER -- requirements
Module: lut_loader

Interface
REQ-001 Parameter H_LEN, default 720, number of horizontal-strip LUT entries.
REQ-002 Parameter V_LEN, default 1280, number of vertical-strip LUT entries.
REQ-003 Parameter TIMEOUT, default 65535, maximum idle clk cycles between bytes while loading.
REQ-004 clk  in  1  SD-domain clock (10 MHz); all logic on its rising edge.
REQ-005 rstn  in  1  synchronous, active-low reset.
REQ-006 start  in  1  level; rising edge requests a load (driven by file_found).
REQ-007 in_valid  in  1  byte strobe from the SD file reader (outen); one byte per high cycle.
REQ-008 in_byte  in  8  file byte, valid when in_valid=1.
REQ-009 rd_h_addr  in  10  H-LUT read address.
REQ-010 rd_h_data  out  8  H-LUT read data.
REQ-011 rd_v_addr  in  11  V-LUT read address.
REQ-012 rd_v_data  out  8  V-LUT read data.
REQ-013 lut_rdy  out  1  both LUTs fully loaded.
REQ-014 busy  out  1  load in progress.
REQ-015 err  out  1  load aborted by timeout.
REQ-016 extra  out  1  bytes arrived after the V-LUT was full.

Function
REQ-017 FSM states IDLE, LOAD_H, LOAD_V, DONE, ERR.
REQ-018 start rising edge is detected against a registered copy of start; the register resets to 0.
REQ-019 IDLE -> LOAD_H on start edge; byte counter, idle counter, err and extra cleared on that transition.
REQ-020 In IDLE, DONE and ERR, no LUT write occurs; a byte coincident with the start edge is discarded.
REQ-021 LOAD_H: each in_valid writes in_byte to H-LUT[cnt] and increments cnt; the write of entry H_LEN-1 moves to LOAD_V with cnt=0.
REQ-022 LOAD_V: each in_valid writes in_byte to V-LUT[cnt] and increments cnt; the write of entry V_LEN-1 moves to DONE.
REQ-023 The first byte after the H->V transition lands in V-LUT[0]; no byte is lost or duplicated at the boundary.
REQ-024 The idle counter increments on each LOAD_H/LOAD_V cycle with in_valid=0 and clears on in_valid=1; reaching TIMEOUT moves to ERR.
REQ-025 When in_valid and timeout coincide, the byte is written and the timeout is not taken.
REQ-026 DONE or ERR -> LOAD_H on a start edge (reload); LUT contents are not cleared and are overwritten in place.
REQ-027 A start edge during LOAD_H/LOAD_V is ignored.
REQ-028 in_valid in DONE sets extra (sticky until next load start); LUTs unchanged.
REQ-029 lut_rdy=1 only in DONE; busy=1 only in LOAD_H/LOAD_V; err=1 only in ERR; all are registered outputs, updated the cycle after the state change.
REQ-030 Read ports are synchronous, 1-cycle latency, independent of FSM state; a read of the address being written in the same cycle returns the old value.
REQ-031 Read addresses >= H_LEN / V_LEN return 8'h00.

Reset
REQ-032 rstn=0 forces IDLE, cnt=0, idle counter=0, lut_rdy=0, busy=0, err=0, extra=0, rd_h_data=0, rd_v_data=0.
REQ-033 Reset mid-load aborts the load; LUT memory contents are not cleared by reset.

Structure
REQ-034 State encoding, H_LEN, V_LEN and TIMEOUT defaults live in the shared SLI package.
REQ-035 One sub-module, lut_ram (single write port, single sync read port, parameterised depth), instantiated once per LUT.

Verification
REQ-036 Reset, start edge, 2000 contiguous bytes value=index[7:0] -> rd_h_data at addr 719 = 8'hCF, rd_v_data at addr 0 = 8'hD0, lut_rdy=1 one cycle after byte 2000.
REQ-037 Bytes with random 0-5 cycle gaps -> same contents as REQ-036; busy=1 throughout, lut_rdy=0 until the last byte.
REQ-038 TIMEOUT=16, stop after 100 bytes -> err=1 on cycle 17 of silence, lut_rdy=0; a second start edge reloads to lut_rdy=1.
REQ-039 2003 bytes -> lut_rdy=1, extra=1, V-LUT[1279] still holds byte 2000.
REQ-040 rstn=0 after 500 bytes -> all outputs zero next cycle, state IDLE; later bytes ignored until start edge.
REQ-041 in_valid on the same cycle as the start edge -> byte discarded; H-LUT[0] takes the next byte.
